cc_display_scanner: RTL
=======================

# cc_display_scanner

Time-multiplexed scan controller for the 4-digit 7-segment display. It sits directly upstream of the digit-select decoder. It produces the 3-bit selection code that the decoder turns into active-low anode enables. It also produces the matching 4-bit nibble for the segment encoder, with a blanking gap between digits to suppress ghosting and a per-frame data snapshot to prevent tearing.

## Interface
Parameters:
- DATAWIDTH_DECODER_SELECTION, 3, width of the selection code sent to the decoder
- DATAWIDTH_DISPLAY_DATA, 16, width of the display word (4 nibbles)
- DATAWIDTH_DIGIT, 4, nibble width per digit
- ON_TICKS, 50000, cycles each digit is driven (≥1)
- BLANK_TICKS, 500, cycles of all-off after each digit (≥0; 0 = no blanking)

Ports:
- CC_DISPLAYSCAN_CLOCK_50  input  1  system clock
- CC_DISPLAYSCAN_RESET_InLow  input  1  reset, asynchronous, active-low
- CC_DISPLAYSCAN_enable_In  input  1  scan enable; 0 = display dark
- CC_DISPLAYSCAN_data_InBUS  input  16  display word; nibble k drives digit k
- CC_DISPLAYSCAN_selection_OutBUS  output  3  to decoder: 3'b000..3'b011 = digit 0..3, 3'b111 = all off
- CC_DISPLAYSCAN_digit_OutBUS  output  4  nibble of the currently selected digit
- CC_DISPLAYSCAN_frame_Out  output  1  one-cycle pulse at each frame start

## Operation
- All outputs are registered. Reset values: selection 3'b111, digit 4'h0, frame 0, state IDLE, index 0, tick counter 0, shadow 16'h0000.
- States: IDLE, SHOW, BLANK.
- IDLE: selection 3'b111.
  - On an edge with enable=1: go to SHOW, index 0, counter 0, shadow ← data_InBUS, frame ← 1.
- SHOW: selection = {1'b0, index[1:0]}, digit = shadow[4*index+3 : 4*index].
  - Counter counts 0..ON_TICKS-1.
  - At the terminal count: if BLANK_TICKS>0, go to BLANK; otherwise advance directly, as at the end of BLANK.
- BLANK: selection 3'b111, digit holds its last value. Counter counts 0..BLANK_TICKS-1.
- At the terminal count of BLANK:
  - Index 0..2: index+1, go to SHOW.
  - Index 3: index wraps to 0, shadow ← data_InBUS, frame ← 1, go to SHOW.
- frame_Out is high only for the cycle in which the first SHOW cycle of digit 0 is presented. It is 0 otherwise.
- data_InBUS is sampled only at frame start. Changes mid-frame are invisible until the next frame.
- enable=0 in any state: on the next edge go to IDLE, selection 3'b111, index 0, counter 0, frame 0. Shadow is retained.
- Simultaneous enable drop and terminal count: the enable drop wins (IDLE).
- The counter width is the clog2 of max(ON_TICKS, BLANK_TICKS, 2). No overflow is possible.
- Selection codes 3'b100..3'b110 are never produced.

## Timing
- Latency from the enable-rise edge to the first digit-0 selection is 1 cycle.
- Latency from the enable-fall edge to selection 3'b111 is 1 cycle.
- Frame period is 4·(ON_TICKS+BLANK_TICKS) cycles. Per digit: ON_TICKS cycles driven, then BLANK_TICKS cycles dark.
- selection and digit change on the same edge, so the decoder and segment path see a consistent pair.
- Reset assertion forces the reset values immediately, without waiting for a clock edge. Deassertion is synchronous to the next edge. Operation restarts from IDLE.
- There is no combinational path from inputs to outputs.

## Test plan
- **Reset:** hold RESET_InLow=0 with enable=1 and data 16'hFFFF.
  - Required: selection 3'b111, digit 0, frame 0.
  - After release, the first edge with enable=1 gives selection 3'b000 and digit 4'h4 for data 16'h1234.
- **Full frame** (ON_TICKS=4, BLANK_TICKS=2, data 16'h1234):
  - Required selection sequence: 000×4, 111×2, 001×4, 111×2, 010×4, 111×2, 011×4, 111×2.
  - Required digits: 4, 3, 2, 1.
  - frame_Out pulses once per 24 cycles, coincident with the first 000 cycle.
- **Anti-tearing:** switch data from 16'h1234 to 16'hABCD during digit 1 SHOW.
  - Required: digits 2 and 3 still show 2 and 1.
  - The next frame shows D, C, B, A.
- **Enable drop:** drop enable in cycle 2 of digit 2 SHOW.
  - Required: next cycle selection 3'b111, frame 0.
  - Re-raise enable: the next cycle gives selection 3'b000 with a fresh snapshot and a frame pulse.
- **Async reset mid-BLANK of digit 3:** required selection stays 3'b111, the index returns to 0, and no frame pulse occurs.
- **BLANK_TICKS=0, ON_TICKS=1:** required selection 000, 001, 010, 011 repeating every cycle, never 111 while enabled, and a frame pulse every 4 cycles.

Source files
------------

// File: rtl/cc_display_scanner.sv
// cc_display_scanner: 4-digit 7-segment scan controller with blanking gap
// and a per-frame data snapshot.
//
// Ports:
//   CC_DISPLAYSCAN_CLOCK_50         in   system clock
//   CC_DISPLAYSCAN_RESET_InLow      in   async active-low reset
//   CC_DISPLAYSCAN_enable_In        in   scan enable (0 = dark)
//   CC_DISPLAYSCAN_data_InBUS       in   display word, nibble k -> digit k
//   CC_DISPLAYSCAN_selection_OutBUS out  decoder code, 0..3 digit, '1 = off
//   CC_DISPLAYSCAN_digit_OutBUS     out  nibble of the selected digit
//   CC_DISPLAYSCAN_frame_Out        out  pulse on first digit-0 cycle
module cc_display_scanner #(
    parameter int DATAWIDTH_DECODER_SELECTION = 3,
    parameter int DATAWIDTH_DISPLAY_DATA      = 16,
    parameter int DATAWIDTH_DIGIT             = 4,
    parameter int ON_TICKS                    = 50000,
    parameter int BLANK_TICKS                 = 500
) (
    input  logic                                   CC_DISPLAYSCAN_CLOCK_50,
    input  logic                                   CC_DISPLAYSCAN_RESET_InLow,
    input  logic                                   CC_DISPLAYSCAN_enable_In,
    input  logic [DATAWIDTH_DISPLAY_DATA-1:0]      CC_DISPLAYSCAN_data_InBUS,
    output logic [DATAWIDTH_DECODER_SELECTION-1:0] CC_DISPLAYSCAN_selection_OutBUS,
    output logic [DATAWIDTH_DIGIT-1:0]             CC_DISPLAYSCAN_digit_OutBUS,
    output logic                                   CC_DISPLAYSCAN_frame_Out
);

    localparam int SW   = DATAWIDTH_DECODER_SELECTION;
    localparam int DW   = DATAWIDTH_DIGIT;
    localparam int MAXT = (ON_TICKS > BLANK_TICKS)
                        ? ((ON_TICKS > 2) ? ON_TICKS : 2)
                        : ((BLANK_TICKS > 2) ? BLANK_TICKS : 2);
    localparam int CW   = $clog2(MAXT);

    localparam logic [CW-1:0] ON_LAST    = CW'(ON_TICKS - 1);
    // Unused when BLANK_TICKS is 0: BLANK is then never entered.
    localparam logic [CW-1:0] BLANK_LAST =
        CW'((BLANK_TICKS > 0) ? (BLANK_TICKS - 1) : 0);
    localparam logic [SW-1:0] SEL_OFF    = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHOW,
        ST_BLANK
    } state_t;

    state_t                  r_state;
    logic [1:0]              r_index;
    logic [CW-1:0]           r_cnt;
    logic [3:0][DW-1:0]      r_shadow;
    logic [SW-1:0]           r_sel;
    logic [DW-1:0]           r_digit;
    logic                    r_frame;

    state_t                  w_state;
    logic [1:0]              w_index;
    logic [CW-1:0]           w_cnt;
    logic [3:0][DW-1:0]      w_shadow;
    logic [SW-1:0]           w_sel;
    logic [DW-1:0]           w_digit;
    logic                    w_frame;
    logic                    w_adv;
    logic [1:0]              w_nidx;

    always_ff @(posedge CC_DISPLAYSCAN_CLOCK_50 or negedge CC_DISPLAYSCAN_RESET_InLow) begin
        if (!CC_DISPLAYSCAN_RESET_InLow) begin
            r_state  <= ST_IDLE;
            r_index  <= 2'd0;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_sel    <= SEL_OFF;
            r_digit  <= '0;
            r_frame  <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_index  <= w_index;
            r_cnt    <= w_cnt;
            r_shadow <= w_shadow;
            r_sel    <= w_sel;
            r_digit  <= w_digit;
            r_frame  <= w_frame;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_index  = r_index;
        w_cnt    = r_cnt;
        w_shadow = r_shadow;
        w_sel    = r_sel;
        w_digit  = r_digit;
        w_frame  = 1'b0;
        w_adv    = 1'b0;
        w_nidx   = r_index + 2'd1;

        if (!CC_DISPLAYSCAN_enable_In) begin
            // Enable drop overrides any terminal count; shadow is kept.
            w_state = ST_IDLE;
            w_index = 2'd0;
            w_cnt   = '0;
            w_sel   = SEL_OFF;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    w_state  = ST_SHOW;
                    w_index  = 2'd0;
                    w_cnt    = '0;
                    w_shadow = CC_DISPLAYSCAN_data_InBUS;
                    w_sel    = '0;
                    w_digit  = CC_DISPLAYSCAN_data_InBUS[DW-1:0];
                    w_frame  = 1'b1;
                end
                ST_SHOW: begin
                    if (r_cnt == ON_LAST) begin
                        if (BLANK_TICKS > 0) begin
                            w_state = ST_BLANK;
                            w_cnt   = '0;
                            w_sel   = SEL_OFF;
                        end else begin
                            w_adv = 1'b1;
                        end
                    end else begin
                        w_cnt = r_cnt + CW'(1);
                    end
                end
                ST_BLANK: begin
                    if (r_cnt == BLANK_LAST) begin
                        w_adv = 1'b1;
                    end else begin
                        w_cnt = r_cnt + CW'(1);
                    end
                end
                default: begin
                    w_state = ST_IDLE;
                    w_index = 2'd0;
                    w_cnt   = '0;
                    w_sel   = SEL_OFF;
                end
            endcase

            // Step to the next digit; wrapping past digit 3 starts a new
            // frame with a fresh snapshot so a frame never tears.
            if (w_adv) begin
                w_state = ST_SHOW;
                w_cnt   = '0;
                w_index = w_nidx;
                w_sel   = SW'(w_nidx);
                if (r_index == 2'd3) begin
                    w_shadow = CC_DISPLAYSCAN_data_InBUS;
                    w_digit  = CC_DISPLAYSCAN_data_InBUS[DW-1:0];
                    w_frame  = 1'b1;
                end else begin
                    w_digit  = r_shadow[w_nidx];
                end
            end
        end
    end

    assign CC_DISPLAYSCAN_selection_OutBUS = r_sel;
    assign CC_DISPLAYSCAN_digit_OutBUS     = r_digit;
    assign CC_DISPLAYSCAN_frame_Out        = r_frame;

endmodule
